// File: rtl/alu_op_issue.sv
// alu_op_issue: RV32I decode-and-issue stage producing the ALU function select,
// operand selects, immediate and control flags behind a skid-buffered handshake.
module alu_op_issue #(
  parameter int XLEN         = 32,
  parameter bit RESET_PC_SEL = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_op,
  output logic            a_sel_pc,
  output logic            b_sel_imm,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic            jump,
  output logic            illegal
);
  typedef struct packed {
    logic [3:0]      alu_op;
    logic            a_sel_pc;
    logic            b_sel_imm;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            illegal;
  } bundle_t;

  localparam bundle_t RST_B = '{a_sel_pc: RESET_PC_SEL, default: '0};

  logic [6:0]  w_opc, w_f7;
  logic [2:0]  w_f3;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic        w_bad, w_in_fire, w_out_load;
  bundle_t     w_dec, r_out, r_skid;
  logic        r_out_valid, r_skid_valid;

  assign w_opc   = in_instr[6:0];
  assign w_f3    = in_instr[14:12];
  assign w_f7    = in_instr[31:25];
  assign w_imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign w_imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign w_imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign w_imm_u = {in_instr[31:12], 12'b0};
  assign w_imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  always_comb begin
    w_dec     = '0;
    w_bad     = 1'b0;
    w_dec.rs1 = in_instr[19:15];
    w_dec.rs2 = in_instr[24:20];
    w_dec.rd  = in_instr[11:7];
    case (w_opc)
      7'b0110011: begin
        w_dec.alu_op    = {w_f7[5], w_f3};
        w_dec.reg_write = 1'b1;
        w_bad = !(w_f7 == 7'b0 || (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)));
      end
      7'b0010011: begin
        w_dec.alu_op    = {(w_f3 == 3'b101) & w_f7[5], w_f3};
        w_dec.b_sel_imm = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.imm       = (w_f3 == 3'b001 || w_f3 == 3'b101) ? {27'b0, in_instr[24:20]} : w_imm_i;
        w_bad = (w_f3 == 3'b001 && w_f7 != 7'b0) ||
                (w_f3 == 3'b101 && w_f7 != 7'b0 && w_f7 != 7'b0100000);
      end
      7'b0000011: begin
        w_dec.b_sel_imm = 1'b1;
        w_dec.imm       = w_imm_i;
        w_dec.mem_read  = 1'b1;
        w_dec.reg_write = 1'b1;
        w_bad = w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111;
      end
      7'b0100011: begin
        w_dec.b_sel_imm = 1'b1;
        w_dec.imm       = w_imm_s;
        w_dec.mem_write = 1'b1;
        w_bad = w_f3 > 3'b010;
      end
      7'b1100011: begin
        // Branch compares: 00x subtract for eq/ne, 10x signed, 11x unsigned
        w_dec.alu_op = w_f3[2] ? {3'b001, w_f3[1]} : 4'b1000;
        w_dec.branch = 1'b1;
        w_dec.imm    = w_imm_b;
        w_bad = w_f3[2:1] == 2'b01;
      end
      7'b0110111: begin
        w_dec.alu_op    = 4'b1001;
        w_dec.b_sel_imm = 1'b1;
        w_dec.imm       = w_imm_u;
        w_dec.reg_write = 1'b1;
      end
      7'b0010111: begin
        w_dec.a_sel_pc  = 1'b1;
        w_dec.b_sel_imm = 1'b1;
        w_dec.imm       = w_imm_u;
        w_dec.reg_write = 1'b1;
      end
      7'b1101111: begin
        w_dec.a_sel_pc  = 1'b1;
        w_dec.b_sel_imm = 1'b1;
        w_dec.imm       = w_imm_j;
        w_dec.jump      = 1'b1;
        w_dec.reg_write = 1'b1;
      end
      7'b1100111: begin
        w_dec.b_sel_imm = 1'b1;
        w_dec.imm       = w_imm_i;
        w_dec.jump      = 1'b1;
        w_dec.reg_write = 1'b1;
        w_bad = w_f3 != 3'b000;
      end
      default: w_bad = 1'b1;
    endcase
    if (w_bad) begin
      w_dec.alu_op    = 4'b0000;
      w_dec.reg_write = 1'b0;
      w_dec.mem_read  = 1'b0;
      w_dec.mem_write = 1'b0;
      w_dec.branch    = 1'b0;
      w_dec.jump      = 1'b0;
      w_dec.illegal   = 1'b1;
    end
  end

  assign in_ready   = !r_skid_valid;
  assign w_in_fire  = in_valid && !r_skid_valid;
  assign w_out_load = !r_out_valid || out_ready;

  // The skid only ever fills while the output is stalled, so draining it
  // always takes priority over new input and preserves order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out        <= RST_B;
      r_skid       <= RST_B;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_load) begin
      r_out_valid  <= r_skid_valid || w_in_fire;
      r_skid_valid <= 1'b0;
      if (r_skid_valid) r_out <= r_skid;
      else if (w_in_fire) r_out <= w_dec;
    end else if (w_in_fire) begin
      r_skid_valid <= 1'b1;
      r_skid       <= w_dec;
    end
  end

  assign out_valid = r_out_valid;
  assign alu_op    = r_out.alu_op;
  assign a_sel_pc  = r_out.a_sel_pc;
  assign b_sel_imm = r_out.b_sel_imm;
  assign imm       = r_out.imm;
  assign rs1       = r_out.rs1;
  assign rs2       = r_out.rs2;
  assign rd        = r_out.rd;
  assign reg_write = r_out.reg_write;
  assign mem_read  = r_out.mem_read;
  assign mem_write = r_out.mem_write;
  assign branch    = r_out.branch;
  assign jump      = r_out.jump;
  assign illegal   = r_out.illegal;
endmodule

// File: tb/tb_alu_op_issue.sv
// tb_alu_op_issue: directed self-checking bench for the decode-and-issue stage,
// covering decode, throughput, backpressure ordering, flush and async reset.
module tb_alu_op_issue;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, imm;
  logic [3:0]  alu_op;
  logic        a_sel_pc, b_sel_imm, reg_write, mem_read, mem_write, branch, jump, illegal;
  logic [4:0]  rs1, rs2, rd;
  int          n_checks = 0;
  int          n_fail = 0;

  alu_op_issue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .a_sel_pc(a_sel_pc), .b_sel_imm(b_sel_imm), .imm(imm),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .jump(jump), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_instr = '0;
    #2;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_checks++; if ({alu_op, imm, reg_write, illegal} !== '0) begin n_fail++; $display("FAIL reset_regs got alu_op=%h imm=%h", alu_op, imm); end
    step(); step();
    rst_n = 1'b1;
    step();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_add();
    in_valid = 1'b1; in_instr = 32'h002081B3;
    step();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid got %b exp 1", out_valid); end
    n_checks++; if ({alu_op, rs1, rs2, rd, reg_write, b_sel_imm} !== {4'h0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0})
      begin n_fail++; $display("FAIL add_fields got op=%h rs1=%0d rs2=%0d rd=%0d rw=%b bimm=%b exp 0/1/2/3/1/0", alu_op, rs1, rs2, rd, reg_write, b_sel_imm); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_instr = 32'h402081B3;
    step();
    in_instr = 32'h40335293;
    n_checks++; if ({out_valid, alu_op} !== {1'b1, 4'b1000}) begin n_fail++; $display("FAIL b2b_sub got v=%b op=%b exp 1/1000", out_valid, alu_op); end
    step();
    in_valid = 1'b0;
    n_checks++; if ({out_valid, alu_op, imm, b_sel_imm, rs1, rd} !== {1'b1, 4'b1101, 32'h3, 1'b1, 5'd6, 5'd5})
      begin n_fail++; $display("FAIL b2b_srai got v=%b op=%b imm=%h bimm=%b rs1=%0d rd=%0d", out_valid, alu_op, imm, b_sel_imm, rs1, rd); end
    step();
  endtask

  task automatic test_load_lui();
    in_valid = 1'b1; in_instr = 32'hFFC12083;
    step();
    in_instr = 32'h123450B7;
    n_checks++; if ({alu_op, imm, mem_read, reg_write, b_sel_imm, rs1, rd} !== {4'h0, 32'hFFFFFFFC, 1'b1, 1'b1, 1'b1, 5'd2, 5'd1})
      begin n_fail++; $display("FAIL lw got op=%h imm=%h mr=%b rs1=%0d rd=%0d", alu_op, imm, mem_read, rs1, rd); end
    step();
    in_valid = 1'b0;
    n_checks++; if ({alu_op, imm, b_sel_imm, reg_write, mem_read} !== {4'b1001, 32'h12345000, 1'b1, 1'b1, 1'b0})
      begin n_fail++; $display("FAIL lui got op=%b imm=%h bimm=%b rw=%b mr=%b", alu_op, imm, b_sel_imm, reg_write, mem_read); end
    step();
  endtask

  task automatic test_formats();
    in_valid = 1'b1; in_instr = 32'h0020E063;
    step();
    in_instr = 32'h0020A423;
    n_checks++; if ({alu_op, branch, reg_write, imm, rs1, rs2} !== {4'b0011, 1'b1, 1'b0, 32'h0, 5'd1, 5'd2})
      begin n_fail++; $display("FAIL bltu got op=%b br=%b rw=%b imm=%h", alu_op, branch, reg_write, imm); end
    step();
    in_instr = 32'h008000EF;
    n_checks++; if ({alu_op, mem_write, b_sel_imm, imm, reg_write} !== {4'h0, 1'b1, 1'b1, 32'h8, 1'b0})
      begin n_fail++; $display("FAIL sw got op=%b mw=%b bimm=%b imm=%h rw=%b", alu_op, mem_write, b_sel_imm, imm, reg_write); end
    step();
    in_valid = 1'b0;
    n_checks++; if ({alu_op, a_sel_pc, b_sel_imm, jump, reg_write, imm, rd} !== {4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h8, 5'd1})
      begin n_fail++; $display("FAIL jal got op=%b pc=%b bimm=%b j=%b rw=%b imm=%h rd=%0d", alu_op, a_sel_pc, b_sel_imm, jump, reg_write, imm, rd); end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h002081B3;
    step();
    in_instr = 32'h402081B3;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready1 got %b exp 1", in_ready); end
    step();
    in_instr = 32'h0020C1B3;
    n_checks++; if ({in_ready, out_valid, alu_op} !== {1'b0, 1'b1, 4'h0}) begin n_fail++; $display("FAIL bp_full got rdy=%b v=%b op=%b exp 0/1/0000", in_ready, out_valid, alu_op); end
    step(); step();
    n_checks++; if ({in_ready, out_valid, alu_op} !== {1'b0, 1'b1, 4'h0}) begin n_fail++; $display("FAIL bp_hold got rdy=%b v=%b op=%b exp 0/1/0000", in_ready, out_valid, alu_op); end
    out_ready = 1'b1;
    step();
    n_checks++; if ({out_valid, alu_op, in_ready} !== {1'b1, 4'b1000, 1'b1}) begin n_fail++; $display("FAIL bp_second got v=%b op=%b rdy=%b exp 1/1000/1", out_valid, alu_op, in_ready); end
    step();
    in_valid = 1'b0;
    n_checks++; if ({out_valid, alu_op} !== {1'b1, 4'b0100}) begin n_fail++; $display("FAIL bp_third got v=%b op=%b exp 1/0100", out_valid, alu_op); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_nodup got %b exp 0", out_valid); end
  endtask

  task automatic test_illegal();
    in_valid = 1'b1; in_instr = 32'h0000007F;
    step();
    in_instr = 32'h022081B3;
    n_checks++; if ({out_valid, illegal, alu_op, reg_write, mem_read, mem_write, branch, jump} !== {1'b1, 1'b1, 4'h0, 5'b0})
      begin n_fail++; $display("FAIL illegal_opc got v=%b ill=%b op=%b flags=%b", out_valid, illegal, alu_op, {reg_write, mem_read, mem_write, branch, jump}); end
    step();
    in_valid = 1'b0;
    n_checks++; if ({out_valid, illegal, alu_op, reg_write, mem_read, mem_write, branch, jump} !== {1'b1, 1'b1, 4'h0, 5'b0})
      begin n_fail++; $display("FAIL illegal_f7 got v=%b ill=%b op=%b flags=%b", out_valid, illegal, alu_op, {reg_write, mem_read, mem_write, branch, jump}); end
    step();
  endtask

  task automatic fill_stalled();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h002081B3;
    step();
    in_instr = 32'h402081B3;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_flush();
    fill_stalled();
    n_checks++; if ({in_ready, out_valid} !== 2'b01) begin n_fail++; $display("FAIL flush_pre got rdy=%b v=%b exp 0/1", in_ready, out_valid); end
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h0020C1B3;
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL flush_full got v=%b rdy=%b exp 0/1", out_valid, in_ready); end
    out_ready = 1'b1;
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_residue got %b exp 0", out_valid); end
    flush = 1'b1; in_valid = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drops_input got %b exp 0", out_valid); end
  endtask

  task automatic test_reset_mid_stall();
    fill_stalled();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({out_valid, in_ready, alu_op} !== {1'b0, 1'b1, 4'h0}) begin n_fail++; $display("FAIL async_reset got v=%b rdy=%b op=%b exp 0/1/0000", out_valid, in_ready, alu_op); end
    step();
    rst_n = 1'b1; out_ready = 1'b1;
    step();
    n_checks++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL reset_residue got v=%b rdy=%b exp 0/1", out_valid, in_ready); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_load_lui();
    test_formats();
    test_backpressure();
    test_illegal();
    test_flush();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
